// File: rtl/rps_pkg.sv
// rps_pkg: shared evaluator, winner and match-state codes for the match scorer.
package rps_pkg;
  localparam logic [2:0] GS_IDLE     = 3'b000;
  localparam logic [2:0] GS_EVALUATE = 3'b001;
  localparam logic [2:0] GS_RESULT   = 3'b010;
  localparam logic [1:0] W_TIE     = 2'b00;
  localparam logic [1:0] W_P1      = 2'b01;
  localparam logic [1:0] W_P2      = 2'b10;
  localparam logic [1:0] W_INVALID = 2'b11;
  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_PLAY = 2'b01;
  localparam logic [1:0] M_DONE = 2'b10;
endpackage

// File: rtl/rps_match_scorer_round_detect.sv
// rps_round_detect: one strobe per entry into the evaluator RESULT state, with the verdict sampled alongside.
module rps_round_detect
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic [1:0] game_winner,
  output logic       round_valid,
  output logic [1:0] win
);
  logic [2:0] prev_state_q, prev_state_d;
  logic       armed_q, armed_d;
  // armed_q blocks a RESULT that was already present when reset released
  always_comb begin
    prev_state_d = game_state;
    armed_d      = 1'b1;
    round_valid  = armed_q && game_state == GS_RESULT && prev_state_q != GS_RESULT;
    win          = game_winner;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_state_q <= GS_IDLE;
      armed_q      <= 1'b0;
    end else begin
      prev_state_q <= prev_state_d;
      armed_q      <= armed_d;
    end
  end
endmodule

// File: rtl/rps_match_scorer.sv
// rps_match_scorer: per-round scoring and first-to-target match decision with round cap and invalid-streak abort.
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET  = 3,
  parameter int MAX_ROUNDS  = 9,
  parameter int MAX_INVALID = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic [1:0] game_winner,
  input  logic       new_match,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [3:0] tie_count,
  output logic [3:0] round_count,
  output logic [1:0] match_state,
  output logic [1:0] match_winner,
  output logic       round_pulse
);
  localparam logic [2:0] WT = 3'(WIN_TARGET);
  localparam logic [3:0] MR = 4'(MAX_ROUNDS);
  localparam logic [2:0] MI = 3'(MAX_INVALID);
  logic       round_valid;
  logic [1:0] win;
  logic [2:0] p1_q, p1_d, p1_n, p2_q, p2_d, p2_n, inv_q, inv_d, inv_n;
  logic [3:0] tie_q, tie_d, tie_n, rnd_q, rnd_d, rnd_n;
  logic [1:0] ms_q, ms_d, mw_q, mw_d, end_w;
  logic       pulse_q, pulse_d, score, done;
  rps_round_detect u_detect (
    .clk        (clk),
    .reset      (reset),
    .game_state (game_state),
    .game_winner(game_winner),
    .round_valid(round_valid),
    .win        (win)
  );
  // *_n are post-round values; end checks must see them, not the current counts
  always_comb begin
    p1_n    = p1_q + 3'(win == W_P1);
    p2_n    = p2_q + 3'(win == W_P2);
    tie_n   = (win == W_TIE && tie_q != 4'hf) ? tie_q + 4'd1 : tie_q;
    rnd_n   = rnd_q + 4'd1;
    inv_n   = (win == W_INVALID) ? inv_q + 3'd1 : 3'd0;
    done    = p1_n == WT || p2_n == WT || inv_n == MI || rnd_n == MR;
    end_w   = p1_n == WT ? W_P1 : p2_n == WT ? W_P2 : inv_n == MI ? W_INVALID :
              p1_n > p2_n ? W_P1 : p2_n > p1_n ? W_P2 : W_TIE;
    score   = !new_match && round_valid && ms_q != M_DONE;
    p1_d    = new_match ? 3'd0 : score ? p1_n : p1_q;
    p2_d    = new_match ? 3'd0 : score ? p2_n : p2_q;
    tie_d   = new_match ? 4'd0 : score ? tie_n : tie_q;
    rnd_d   = new_match ? 4'd0 : score ? rnd_n : rnd_q;
    inv_d   = new_match ? 3'd0 : score ? inv_n : inv_q;
    ms_d    = new_match ? M_IDLE : score ? (done ? M_DONE : M_PLAY) : ms_q;
    mw_d    = new_match ? W_TIE : (score && done) ? end_w : mw_q;
    pulse_d = score;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_q    <= '0;
      p2_q    <= '0;
      tie_q   <= '0;
      rnd_q   <= '0;
      inv_q   <= '0;
      ms_q    <= M_IDLE;
      mw_q    <= W_TIE;
      pulse_q <= 1'b0;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      tie_q   <= tie_d;
      rnd_q   <= rnd_d;
      inv_q   <= inv_d;
      ms_q    <= ms_d;
      mw_q    <= mw_d;
      pulse_q <= pulse_d;
    end
  end
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign tie_count    = tie_q;
  assign round_count  = rnd_q;
  assign match_state  = ms_q;
  assign match_winner = mw_q;
  assign round_pulse  = pulse_q;
endmodule

// File: tb/tb_rps_match_scorer.sv
// tb_rps_match_scorer: directed checks of scoring, match end conditions, new_match precedence and async reset.
module tb_rps_match_scorer;
  import rps_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] gs = GS_IDLE;
  logic [1:0] gw = W_TIE;
  logic       nm = 1'b0;
  logic [2:0] a_p1, a_p2, b_p1, b_p2;
  logic [3:0] a_tie, a_rnd, b_tie, b_rnd;
  logic [1:0] a_ms, a_mw, b_ms, b_mw;
  logic       a_pulse, b_pulse;
  int n_cmp = 0;
  int n_err = 0;
  int first, total;
  always #5 clk = ~clk;
  rps_match_scorer u_a (
    .clk(clk), .reset(reset), .game_state(gs), .game_winner(gw), .new_match(nm),
    .p1_score(a_p1), .p2_score(a_p2), .tie_count(a_tie), .round_count(a_rnd),
    .match_state(a_ms), .match_winner(a_mw), .round_pulse(a_pulse)
  );
  rps_match_scorer #(.WIN_TARGET(3), .MAX_ROUNDS(4), .MAX_INVALID(3)) u_b (
    .clk(clk), .reset(reset), .game_state(gs), .game_winner(gw), .new_match(nm),
    .p1_score(b_p1), .p2_score(b_p2), .tie_count(b_tie), .round_count(b_rnd),
    .match_state(b_ms), .match_winner(b_mw), .round_pulse(b_pulse)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic round(input logic [1:0] w, output int f, output int t);
    gs = GS_EVALUATE; gw = w; tick();
    gs = GS_RESULT; tick();
    f = int'(a_pulse); t = int'(a_pulse);
    repeat (4) begin tick(); t += int'(a_pulse); end
    gs = GS_IDLE; tick();
  endtask
  task automatic clear();
    nm = 1'b1; tick(); nm = 1'b0;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_p1", a_p1, 0); chk("rst_rnd", a_rnd, 0); chk("rst_ms", a_ms, 0);
    chk("rst_mw", a_mw, 0); chk("rst_pulse", a_pulse, 0);
    #2 reset = 1'b0;
    tick();
    round(W_P1, first, total);
    chk("p1w1_score", a_p1, 1); chk("p1w1_first", first, 1); chk("p1w1_total", total, 1);
    chk("p1w1_ms", a_ms, 1);
    round(W_P1, first, total);
    chk("p1w2_score", a_p1, 2); chk("p1w2_total", total, 1);
    round(W_P1, first, total);
    chk("p1w3_score", a_p1, 3); chk("p1w3_first", first, 1); chk("p1w3_ms", a_ms, 2);
    chk("p1w3_mw", a_mw, 1); chk("p1w3_rnd", a_rnd, 3);
    round(W_P2, first, total);
    chk("done_ignore_pulse", total, 0); chk("done_ignore_p2", a_p2, 0); chk("done_ignore_rnd", a_rnd, 3);
    clear();
    chk("clr_p1", a_p1, 0); chk("clr_ms", a_ms, 0); chk("clr_mw", a_mw, 0); chk("clr_rnd", a_rnd, 0);
    round(W_TIE, first, total); round(W_P2, first, total); round(W_P1, first, total);
    round(W_P2, first, total);
    chk("seq2_r4_ms", a_ms, 1);
    round(W_P2, first, total);
    chk("seq2_tie", a_tie, 1); chk("seq2_p1", a_p1, 1); chk("seq2_p2", a_p2, 3);
    chk("seq2_mw", a_mw, 2); chk("seq2_ms", a_ms, 2); chk("seq2_rnd", a_rnd, 5);
    round(W_P1, first, total);
    chk("seq2_after_pulse", total, 0); chk("seq2_after_p1", a_p1, 1); chk("seq2_after_rnd", a_rnd, 5);
    clear();
    round(W_P1, first, total); round(W_INVALID, first, total); round(W_INVALID, first, total);
    chk("inv2_ms", a_ms, 1);
    round(W_INVALID, first, total);
    chk("inv3_mw", a_mw, 3); chk("inv3_ms", a_ms, 2); chk("inv3_p1", a_p1, 1); chk("inv3_rnd", a_rnd, 4);
    clear();
    round(W_INVALID, first, total); round(W_P1, first, total);
    round(W_INVALID, first, total); round(W_INVALID, first, total);
    chk("invbrk_ms", a_ms, 1); chk("invbrk_mw", a_mw, 0); chk("invbrk_rnd", a_rnd, 4); chk("invbrk_p1", a_p1, 1);
    clear();
    round(W_P1, first, total); round(W_P2, first, total); round(W_TIE, first, total);
    round(W_TIE, first, total);
    chk("cap_b_ms", b_ms, 2); chk("cap_b_mw", b_mw, 0); chk("cap_b_tie", b_tie, 2); chk("cap_a_ms", a_ms, 1);
    clear();
    round(W_P1, first, total); round(W_P1, first, total); round(W_P2, first, total);
    round(W_TIE, first, total);
    chk("cap2_b_ms", b_ms, 2); chk("cap2_b_mw", b_mw, 1); chk("cap2_b_p1", b_p1, 2); chk("cap2_b_rnd", b_rnd, 4);
    clear();
    round(W_P1, first, total);
    chk("nm_pre_p1", a_p1, 1);
    gs = GS_EVALUATE; gw = W_P1; tick();
    gs = GS_RESULT; nm = 1'b1; tick();
    nm = 1'b0;
    chk("nm_same_p1", a_p1, 0); chk("nm_same_rnd", a_rnd, 0); chk("nm_same_ms", a_ms, 0);
    chk("nm_same_pulse", a_pulse, 0);
    repeat (3) tick();
    chk("nm_hold_rnd", a_rnd, 0);
    gs = GS_IDLE; tick();
    round(W_P2, first, total);
    chk("nm_next_p2", a_p2, 1); chk("nm_next_first", first, 1); chk("nm_next_ms", a_ms, 1);
    round(W_P2, first, total);
    chk("ar_pre_p2", a_p2, 2);
    gs = GS_RESULT; gw = W_P2;
    #2 reset = 1'b1;
    #1;
    chk("ar_p2", a_p2, 0); chk("ar_rnd", a_rnd, 0); chk("ar_ms", a_ms, 0); chk("ar_mw", a_mw, 0);
    repeat (2) tick();
    #3 reset = 1'b0;
    repeat (3) tick();
    chk("ar_hold_rnd", a_rnd, 0); chk("ar_hold_p2", a_p2, 0); chk("ar_hold_pulse", a_pulse, 0);
    gs = GS_IDLE; tick();
    round(W_P1, first, total);
    chk("ar_next_p1", a_p1, 1); chk("ar_next_first", first, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
